// File: rtl/microwatt_ext_io_mailbox.sv
// microwatt_ext_io_mailbox: Wishbone slave on the external-IO bus that provides
// NUM_CH bidirectional mailbox channels (TX: CPU->debugger, RX: debugger->CPU),
// each built from two DEPTH-word FIFOs.
// Optional feature macro: MBOX_IRQ_EN adds the mbox_irq output and stores CTRL.irq_en.
module microwatt_ext_io_mailbox #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8
) (
    input  logic                  system_clk,
    input  logic                  rst,
    input  logic                  wb_ext_is_sel,
    input  logic [29:0]           wb_in_adr,
    input  logic [31:0]           wb_in_dat,
    input  logic [3:0]            wb_in_sel,
    input  logic                  wb_in_cyc,
    input  logic                  wb_in_stb,
    input  logic                  wb_in_we,
    output logic [31:0]           wb_out_dat,
    output logic                  wb_out_ack,
    output logic                  wb_out_stall,
    output logic [32*NUM_CH-1:0]  dbg_tx_data,
    output logic [NUM_CH-1:0]     dbg_tx_valid,
    input  logic [NUM_CH-1:0]     dbg_tx_ready,
    input  logic [32*NUM_CH-1:0]  dbg_rx_data,
    input  logic [NUM_CH-1:0]     dbg_rx_valid,
    output logic [NUM_CH-1:0]     dbg_rx_ready
`ifdef MBOX_IRQ_EN
    ,
    output logic                  mbox_irq
`endif
);

    localparam int CHB = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;

    logic                     w_accept;
    logic [1:0]               w_reg;
    logic [CHB-1:0]           w_ch;
    logic [NUM_CH-1:0][31:0]  w_ch_rdata;
    logic [31:0]              w_rdata;
    logic                     r_ack_p1;
    logic [31:0]              r_rdata_p1;
    logic                     w_unused_bits;
`ifdef MBOX_IRQ_EN
    logic [NUM_CH-1:0]        w_irq_req;
    logic                     r_irq;
`endif

    assign w_accept = wb_in_cyc & wb_in_stb & wb_ext_is_sel;
    assign w_reg    = wb_in_adr[1:0];
    assign w_ch     = wb_in_adr[CHB+1:2];

    // Byte enables other than sel[0] and high address bits carry no meaning here
    assign w_unused_bits = &{1'b0, wb_in_sel[3:1], wb_in_adr[29:CHB+2]};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [31:0]   r_tx_mem [DEPTH];
        logic [31:0]   r_rx_mem [DEPTH];
        logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
        logic [CW-1:0] r_tx_cnt, r_rx_cnt;
        logic          r_tx_ovf, r_rx_udf;
        logic          w_hit, w_tx_wr, w_rx_rd, w_ctrl_wr;
        logic          w_tx_flush, w_rx_flush, w_clr_flags;
        logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
        logic          w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
        logic          w_irq_en;
        logic [31:0]   w_status;
        logic [31:0]   w_rd;

        assign w_hit       = w_accept && (w_ch == CHB'(c));
        assign w_tx_wr     = w_hit &  wb_in_we & (w_reg == 2'd0);
        assign w_rx_rd     = w_hit & ~wb_in_we & (w_reg == 2'd1);
        assign w_ctrl_wr   = w_hit &  wb_in_we & (w_reg == 2'd3) & wb_in_sel[0];
        assign w_tx_flush  = w_ctrl_wr & wb_in_dat[0];
        assign w_rx_flush  = w_ctrl_wr & wb_in_dat[1];
        assign w_clr_flags = w_ctrl_wr & wb_in_dat[2];

        // Full/empty come from registered counts only, so a pop never frees a slot in the same cycle
        assign w_tx_full  = (r_tx_cnt == CW'(DEPTH));
        assign w_tx_empty = (r_tx_cnt == '0);
        assign w_rx_full  = (r_rx_cnt == CW'(DEPTH));
        assign w_rx_empty = (r_rx_cnt == '0);

        assign w_tx_push = w_tx_wr & ~w_tx_full;
        assign w_tx_pop  = ~w_tx_empty & dbg_tx_ready[c];
        assign w_rx_push = dbg_rx_valid[c] & ~w_rx_full;
        assign w_rx_pop  = w_rx_rd & ~w_rx_empty;

        assign dbg_tx_valid[c]         = ~w_tx_empty;
        assign dbg_tx_data[32*c +: 32] = w_tx_empty ? 32'd0 : r_tx_mem[r_tx_rp];
        assign dbg_rx_ready[c]         = ~w_rx_full;

        // TX pointers and count; flush wins over any push or pop in the same cycle
        always_ff @(posedge system_clk) begin
            if (rst || w_tx_flush) begin
                r_tx_wp  <= '0;
                r_tx_rp  <= '0;
                r_tx_cnt <= '0;
            end else begin
                if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
                if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
                r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
            end
        end

        // RX pointers and count; flush wins over any push or pop in the same cycle
        always_ff @(posedge system_clk) begin
            if (rst || w_rx_flush) begin
                r_rx_wp  <= '0;
                r_rx_rp  <= '0;
                r_rx_cnt <= '0;
            end else begin
                if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
                if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
                r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
            end
        end

        // Sticky overflow/underflow flags, cleared only by CTRL bit 2 or reset
        always_ff @(posedge system_clk) begin
            if (rst || w_clr_flags) begin
                r_tx_ovf <= 1'b0;
                r_rx_udf <= 1'b0;
            end else begin
                if (w_tx_wr & w_tx_full)  r_tx_ovf <= 1'b1;
                if (w_rx_rd & w_rx_empty) r_rx_udf <= 1'b1;
            end
        end

        // FIFO storage holds data only; validity is tracked by the counts
        always_ff @(posedge system_clk) begin
            if (w_tx_push) r_tx_mem[r_tx_wp] <= wb_in_dat;
            if (w_rx_push) r_rx_mem[r_rx_wp] <= dbg_rx_data[32*c +: 32];
        end

`ifdef MBOX_IRQ_EN
        logic r_irq_en;

        // Interrupt enable bit from CTRL bit 8
        always_ff @(posedge system_clk) begin
            if (rst)            r_irq_en <= 1'b0;
            else if (w_ctrl_wr) r_irq_en <= wb_in_dat[8];
        end

        assign w_irq_en     = r_irq_en;
        assign w_irq_req[c] = r_irq_en & ~w_rx_empty;
`else
        assign w_irq_en = 1'b0;
`endif

        assign w_status = {12'd0, r_rx_udf, r_tx_ovf, w_rx_empty, w_tx_full,
                           8'(r_rx_cnt), 8'(r_tx_cnt)};

        // Read data this channel returns; reflects state before the request's side effect
        always_comb begin
            w_rd = '0;
            if (!wb_in_we) begin
                case (w_reg)
                    2'd1:    if (!w_rx_empty) w_rd = r_rx_mem[r_rx_rp];
                    2'd2:    w_rd = w_status;
                    2'd3:    w_rd = {23'd0, w_irq_en, 8'd0};
                    default: w_rd = '0;
                endcase
            end
        end

        assign w_ch_rdata[c] = w_rd;
    end

    // Select the addressed channel; channels at or beyond NUM_CH read 0
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == CHB'(i)) w_rdata = w_ch_rdata[i];
        end
    end

    // ---- stage p1: acknowledge one cycle after accept ----
    // Ack pipeline register; reset drops a pending ack
    always_ff @(posedge system_clk) begin
        if (rst) r_ack_p1 <= 1'b0;
        else     r_ack_p1 <= w_accept;
    end

    // Read data captured alongside the ack
    always_ff @(posedge system_clk) begin
        r_rdata_p1 <= w_rdata;
    end

    // Ack is withdrawn if the master has dropped cyc; the side effect is already committed
    assign wb_out_ack   = r_ack_p1 & wb_in_cyc;
    assign wb_out_dat   = wb_out_ack ? r_rdata_p1 : 32'd0;
    assign wb_out_stall = 1'b0;

`ifdef MBOX_IRQ_EN
    // Registered interrupt: any enabled channel with RX data pending
    always_ff @(posedge system_clk) begin
        if (rst) r_irq <= 1'b0;
        else     r_irq <= |w_irq_req;
    end

    assign mbox_irq = r_irq;
`endif

endmodule
